// File: rtl/exc_pkg.sv
// Shared encodings for the exception sequencer: FSM states, cause codes
// and PC-source select codes.
package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_VECTOR,
        ST_HANDLER,
        ST_RETURN
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_ILL  = 2'b10;
    localparam logic [1:0] CAUSE_IRQ  = 2'b11;

    localparam logic [1:0] PCSRC_NORMAL = 2'b00;
    localparam logic [1:0] PCSRC_VECTOR = 2'b01;
    localparam logic [1:0] PCSRC_EPC    = 2'b10;

endpackage

// File: rtl/exc_sequencer_if.sv
// Bundle between the CPU control path and the exception sequencer.
// master = CPU/control side, slave = sequencer.
interface exc_sequencer_if #(
    parameter int unsigned CAUSE_W = 2
);
    logic               ex_valid;
    logic               ovf_flag;
    logic               illegal_op;
    logic               eret;
    logic               fetch_boundary;
    logic               irq;
    logic [31:0]        pc_cur;

    logic               exp_write;
    logic               wb_kill;
    logic               stall;
    logic               pc_redirect;
    logic [1:0]         pc_src;
    logic [CAUSE_W-1:0] cause;
    logic [31:0]        epc;
    logic               in_handler;
    logic               double_fault;

    modport master (
        output ex_valid, ovf_flag, illegal_op, eret, fetch_boundary, irq, pc_cur,
        input  exp_write, wb_kill, stall, pc_redirect, pc_src, cause, epc,
               in_handler, double_fault
    );

    modport slave (
        input  ex_valid, ovf_flag, illegal_op, eret, fetch_boundary, irq, pc_cur,
        output exp_write, wb_kill, stall, pc_redirect, pc_src, cause, epc,
               in_handler, double_fault
    );
endinterface

// File: rtl/exc_sequencer_irq_sync.sv
// Synchronizes the asynchronous irq level and emits a one-cycle pulse on
// each synchronized rising edge.
module irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_irq,
    output logic o_irq_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_irq_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: kills the faulting writeback, saves EPC and
// cause, stalls the main FSM and redirects the PC to the handler or back to EPC.
module exc_sequencer
    import exc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CAUSE_W     = 2
) (
    input  logic            clk,
    input  logic            reset,
    exc_sequencer_if.slave  bus
);

    state_t             r_state;
    logic               r_stall;
    logic               r_pc_redirect;
    logic [1:0]         r_pc_src;
    logic [CAUSE_W-1:0] r_cause;
    logic [31:0]        r_epc;
    logic               r_in_handler;
    logic               r_double_fault;
    logic               r_irq_pending;

    logic w_irq_edge;
    logic w_fault;
    logic w_idle;
    logic w_handler;

    irq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_irq_sync (
        .clk       (clk),
        .reset     (reset),
        .i_irq     (bus.irq),
        .o_irq_edge(w_irq_edge)
    );

    assign w_fault   = bus.ex_valid & (bus.illegal_op | bus.ovf_flag);
    assign w_idle    = (r_state == ST_IDLE);
    assign w_handler = (r_state == ST_HANDLER);

    // Mealy strobes are gated by reset so every output is low while it is held.
    assign bus.wb_kill   = ~reset & w_fault & (w_idle | w_handler);
    assign bus.exp_write = ~reset & w_idle & bus.ex_valid & bus.ovf_flag & ~bus.illegal_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_stall        <= 1'b0;
            r_pc_redirect  <= 1'b0;
            r_pc_src       <= PCSRC_NORMAL;
            r_cause        <= '0;
            r_epc          <= '0;
            r_in_handler   <= 1'b0;
            r_double_fault <= 1'b0;
            r_irq_pending  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fault) begin
                        r_state <= ST_SAVE;
                        r_stall <= 1'b1;
                        r_cause <= bus.illegal_op ? CAUSE_W'(CAUSE_ILL) : CAUSE_W'(CAUSE_OVF);
                        r_epc   <= bus.pc_cur;
                    end else if (r_irq_pending && bus.fetch_boundary) begin
                        r_state       <= ST_SAVE;
                        r_stall       <= 1'b1;
                        r_cause       <= CAUSE_W'(CAUSE_IRQ);
                        r_epc         <= bus.pc_cur;
                        r_irq_pending <= 1'b0;
                    end
                end
                ST_SAVE: begin
                    r_state       <= ST_VECTOR;
                    r_stall       <= 1'b1;
                    r_pc_redirect <= 1'b1;
                    r_pc_src      <= PCSRC_VECTOR;
                end
                ST_VECTOR: begin
                    r_state       <= ST_HANDLER;
                    r_stall       <= 1'b0;
                    r_pc_redirect <= 1'b0;
                    r_pc_src      <= PCSRC_NORMAL;
                    r_in_handler  <= 1'b1;
                end
                ST_HANDLER: begin
                    if (w_fault) begin
                        r_double_fault <= 1'b1;
                    end
                    if (bus.ex_valid && bus.eret) begin
                        r_state       <= ST_RETURN;
                        r_stall       <= 1'b1;
                        r_pc_redirect <= 1'b1;
                        r_pc_src      <= PCSRC_EPC;
                    end
                end
                ST_RETURN: begin
                    r_state       <= ST_IDLE;
                    r_stall       <= 1'b0;
                    r_pc_redirect <= 1'b0;
                    r_pc_src      <= PCSRC_NORMAL;
                    r_in_handler  <= 1'b0;
                    r_cause       <= CAUSE_W'(CAUSE_NONE);
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // Placed after the clear so a coincident new edge is not lost.
            if (w_irq_edge) begin
                r_irq_pending <= 1'b1;
            end
        end
    end

    assign bus.stall        = r_stall;
    assign bus.pc_redirect  = r_pc_redirect;
    assign bus.pc_src       = r_pc_src;
    assign bus.cause        = r_cause;
    assign bus.epc          = r_epc;
    assign bus.in_handler   = r_in_handler;
    assign bus.double_fault = r_double_fault;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: a table of single-cycle vectors followed
// by hand-written irq, priority and async-reset sequences.
module tb_exc_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    exc_sequencer_if #(.CAUSE_W(2)) bus ();

    exc_sequencer #(
        .SYNC_STAGES(2),
        .CAUSE_W    (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic        ov;
        logic        il;
        logic        er;
        logic        fb;
        logic [31:0] pc;
        logic [41:0] exp;
    } vec_t;

    vec_t tbl [19];

    // Packed view: {exp_write, wb_kill, stall, pc_redirect, pc_src, cause, in_handler, double_fault, epc}
    function automatic logic [41:0] E(input logic ew, input logic wk, input logic st,
                                      input logic rd, input logic [1:0] src,
                                      input logic [1:0] c, input logic ih,
                                      input logic df, input logic [31:0] epc);
        return {ew, wk, st, rd, src, c, ih, df, epc};
    endfunction

    function automatic logic [41:0] act();
        return {bus.exp_write, bus.wb_kill, bus.stall, bus.pc_redirect, bus.pc_src,
                bus.cause, bus.in_handler, bus.double_fault, bus.epc};
    endfunction

    task automatic cyc(input logic ev, input logic ov, input logic il, input logic er,
                       input logic fb, input logic [31:0] pc);
        @(negedge clk);
        bus.ex_valid       = ev;
        bus.ovf_flag       = ov;
        bus.illegal_op     = il;
        bus.eret           = er;
        bus.fetch_boundary = fb;
        bus.pc_cur         = pc;
        #1;
    endtask

    task automatic chk(input string nm, input logic [41:0] exp);
        logic [41:0] a;
        a = act();
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, a, exp);
        end
    endtask

    localparam logic [31:0] EP1 = 32'h0040_0010;
    localparam logic [31:0] EP2 = 32'h0040_0040;
    localparam logic [41:0] Z   = '0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        tbl[0]  = '{0,0,0,0,0,32'h0,          E(0,0,0,0,2'd0,2'd0,0,0,32'h0)};
        tbl[1]  = '{1,1,0,0,0,EP1,            E(1,1,0,0,2'd0,2'd0,0,0,32'h0)};
        tbl[2]  = '{0,0,0,0,0,32'h0,          E(0,0,1,0,2'd0,2'd1,0,0,EP1)};
        tbl[3]  = '{0,0,0,0,0,32'h0,          E(0,0,1,1,2'd1,2'd1,0,0,EP1)};
        tbl[4]  = '{0,0,0,0,0,32'h0,          E(0,0,0,0,2'd0,2'd1,1,0,EP1)};
        tbl[5]  = '{1,1,0,0,0,32'h0040_0100,  E(0,1,0,0,2'd0,2'd1,1,0,EP1)};
        tbl[6]  = '{0,0,0,0,0,32'h0,          E(0,0,0,0,2'd0,2'd1,1,1,EP1)};
        tbl[7]  = '{1,0,0,1,0,32'h0,          E(0,0,0,0,2'd0,2'd1,1,1,EP1)};
        tbl[8]  = '{0,0,0,0,0,32'h0,          E(0,0,1,1,2'd2,2'd1,1,1,EP1)};
        tbl[9]  = '{0,0,0,0,0,32'h0,          E(0,0,0,0,2'd0,2'd0,0,1,EP1)};
        tbl[10] = '{1,0,0,1,0,32'h0,          E(0,0,0,0,2'd0,2'd0,0,1,EP1)};
        tbl[11] = '{0,1,1,0,0,32'h0,          E(0,0,0,0,2'd0,2'd0,0,1,EP1)};
        tbl[12] = '{1,1,1,0,0,EP2,            E(0,1,0,0,2'd0,2'd0,0,1,EP1)};
        tbl[13] = '{0,0,0,0,0,32'h0,          E(0,0,1,0,2'd0,2'd2,0,1,EP2)};
        tbl[14] = '{0,0,0,0,0,32'h0,          E(0,0,1,1,2'd1,2'd2,0,1,EP2)};
        tbl[15] = '{0,0,0,0,0,32'h0,          E(0,0,0,0,2'd0,2'd2,1,1,EP2)};
        tbl[16] = '{1,1,0,1,0,32'h0,          E(0,1,0,0,2'd0,2'd2,1,1,EP2)};
        tbl[17] = '{0,0,0,0,0,32'h0,          E(0,0,1,1,2'd2,2'd2,1,1,EP2)};
        tbl[18] = '{0,0,0,0,0,32'h0,          E(0,0,0,0,2'd0,2'd0,0,1,EP2)};

        reset = 1'b1;
        bus.irq = 1'b0;
        bus.ex_valid = 1'b0; bus.ovf_flag = 1'b0; bus.illegal_op = 1'b0;
        bus.eret = 1'b0; bus.fetch_boundary = 1'b0; bus.pc_cur = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].ev, tbl[i].ov, tbl[i].il, tbl[i].er, tbl[i].fb, tbl[i].pc);
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // irq held high for 5 cycles yields exactly one entry.
        @(negedge clk); reset = 1'b1; #1;
        chk("reset_clear", Z);
        @(negedge clk); reset = 1'b0;
        bus.irq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(0,0,0,0,0,32'h0);
            chk("irq_sync_wait", Z);
        end
        bus.irq = 1'b0;
        cyc(0,0,0,0,1,32'h0040_0020);
        chk("irq_fb_cycle", Z);
        cyc(0,0,0,0,0,32'h0);
        chk("irq_entry", E(0,0,1,0,2'd0,2'd3,0,0,32'h0040_0020));
        cyc(0,0,0,0,0,32'h0);
        chk("irq_vector", E(0,0,1,1,2'd1,2'd3,0,0,32'h0040_0020));
        cyc(0,0,0,0,0,32'h0);
        cyc(1,0,0,1,0,32'h0);
        cyc(0,0,0,0,0,32'h0);
        chk("irq_return", E(0,0,1,1,2'd2,2'd3,1,0,32'h0040_0020));
        for (int i = 0; i < 4; i++) begin
            cyc(0,0,0,0,1,32'h0040_0024);
            chk("irq_single", E(0,0,0,0,2'd0,2'd0,0,0,32'h0040_0020));
        end

        // irq edge inside the handler is masked, then a fault beats it, then it is taken.
        cyc(1,1,0,0,0,32'h0040_0030);
        cyc(0,0,0,0,0,32'h0);
        cyc(0,0,0,0,0,32'h0);
        cyc(0,0,0,0,0,32'h0);
        bus.irq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(0,0,0,0,1,32'h0040_0050);
            chk("irq_masked", E(0,0,0,0,2'd0,2'd1,1,0,32'h0040_0030));
        end
        bus.irq = 1'b0;
        cyc(1,0,0,1,0,32'h0);
        cyc(0,0,0,0,0,32'h0);
        chk("ret2", E(0,0,1,1,2'd2,2'd1,1,0,32'h0040_0030));
        cyc(0,0,0,0,0,32'h0);
        chk("irq_wait_fb", E(0,0,0,0,2'd0,2'd0,0,0,32'h0040_0030));
        cyc(1,1,0,0,1,32'h0040_0060);
        chk("fault_vs_irq_kill", E(1,1,0,0,2'd0,2'd0,0,0,32'h0040_0030));
        cyc(0,0,0,0,0,32'h0);
        chk("fault_wins", E(0,0,1,0,2'd0,2'd1,0,0,32'h0040_0060));
        cyc(0,0,0,0,0,32'h0);
        cyc(1,0,0,1,0,32'h0);
        cyc(0,0,0,0,0,32'h0);
        cyc(0,0,0,0,1,32'h0040_0070);
        chk("irq_after_ret", E(0,0,0,0,2'd0,2'd0,0,0,32'h0040_0060));
        cyc(0,0,0,0,0,32'h0);
        chk("irq_deferred", E(0,0,1,0,2'd0,2'd3,0,0,32'h0040_0070));

        // Async reset while in VECTOR, then a clean fault sequence.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        cyc(1,1,0,0,0,32'h0040_0200);
        cyc(0,0,0,0,0,32'h0);
        cyc(0,0,0,0,0,32'h0);
        chk("vector_pre_reset", E(0,0,1,1,2'd1,2'd1,0,0,32'h0040_0200));
        #2; reset = 1'b1; #1;
        chk("async_reset", Z);
        @(negedge clk); reset = 1'b0;
        cyc(1,1,0,0,0,32'h0040_0300);
        chk("post_reset_kill", E(1,1,0,0,2'd0,2'd0,0,0,32'h0));
        cyc(0,0,0,0,0,32'h0);
        chk("post_reset_save", E(0,0,1,0,2'd0,2'd1,0,0,32'h0040_0300));
        cyc(0,0,0,0,0,32'h0);
        chk("post_reset_vector", E(0,0,1,1,2'd1,2'd1,0,0,32'h0040_0300));
        cyc(0,0,0,0,0,32'h0);
        chk("post_reset_handler", E(0,0,0,0,2'd0,2'd1,1,0,32'h0040_0300));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
